// File: rtl/cmp_sort_ctrl.sv
// Burst sorter: loads N unsigned 4-bit values, bubble-sorts them through one shared comparator, streams them out ascending.
// Latency: one compare per cycle; N-1 compares when already sorted, N(N-1)/2 worst case; the first output follows the last compare.
// Backpressure: in_ready only in LOAD, out_valid only in DRAIN; out_data is held while out_ready is low.

// Purely combinational 4-bit unsigned magnitude comparator.
// Latency: zero cycles.
// Backpressure: none (no handshake).
module FourBitComparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       gt,
  output logic       eq
);

  // Exactly one of lt/gt/eq is high for any operand pair
  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

module cmp_sort_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic [5:0] swap_count
);

  localparam int IW = (N <= 2) ? 1 : $clog2(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [3:0]    mem [N];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] j;
  logic [IW-1:0] j_p1;
  logic [IW-1:0] pass;
  logic          pass_swapped;

  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic          cmp_lt;
  logic          cmp_gt;
  logic          cmp_eq;

  logic          load_hs;
  logic          load_last;
  logic          drain_hs;
  logic          drain_last;
  logic          do_swap;
  logic          pass_end;
  logic          sort_done;

  // The single comparator always looks at the adjacent pair selected by j
  assign j_p1 = j + IW'(1);
  assign op_a = mem[j];
  assign op_b = mem[j_p1];

  FourBitComparator u_cmp (
    .a  (op_a),
    .b  (op_b),
    .lt (cmp_lt),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  // Handshake and sort-progress decode; only a strict greater-than swaps, which keeps equal keys in order
  always_comb begin
    load_hs    = (state == ST_LOAD) && in_valid;
    load_last  = load_hs && (wr_idx == LAST_IDX);
    drain_hs   = (state == ST_DRAIN) && out_ready;
    drain_last = drain_hs && (rd_idx == LAST_IDX);
    do_swap    = (state == ST_SORT) && ({cmp_lt, cmp_eq, cmp_gt} == 3'b001);
    pass_end   = (j == (LAST_PASS - pass));
    sort_done  = pass_end && ((pass == LAST_PASS) || !(pass_swapped || do_swap));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (load_last)  state_nxt = ST_SORT;
      ST_SORT:  if (sort_done)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_nxt = ST_LOAD;
      default:                  state_nxt = ST_LOAD;
    endcase
  end

  // Port decode from registered state only, so no input-to-output combinational path exists
  always_comb begin
    in_ready  = (state == ST_LOAD);
    out_valid = (state == ST_DRAIN);
    busy      = (state == ST_SORT) || (state == ST_DRAIN);
    out_data  = (state == ST_DRAIN) ? mem[rd_idx] : 4'd0;
  end

  // Register file, indices and swap bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= 4'd0;
      end
      wr_idx       <= '0;
      rd_idx       <= '0;
      j            <= '0;
      pass         <= '0;
      swap_count   <= 6'd0;
      pass_swapped <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_hs) begin
            mem[wr_idx] <= in_data;
            if (load_last) begin
              wr_idx       <= '0;
              j            <= '0;
              pass         <= '0;
              swap_count   <= 6'd0;
              pass_swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        ST_SORT: begin
          if (do_swap) begin
            mem[j]       <= op_b;
            mem[j_p1]    <= op_a;
            swap_count   <= swap_count + 6'd1;
            pass_swapped <= 1'b1;
          end
          if (!pass_end) begin
            j <= j_p1;
          end else if (!sort_done) begin
            // Start the next pass; this clear overrides the set above
            pass         <= pass + IW'(1);
            j            <= '0;
            pass_swapped <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_hs) begin
            rd_idx <= drain_last ? '0 : (rd_idx + IW'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Bench for cmp_sort_ctrl: directed bursts plus random bursts against a behavioural model.
// Latency: measures compare cycles between the last load and the first output.
// Backpressure: exercises held out_ready=0 and random out_ready during drain.
module tb_cmp_sort_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [5:0] swap_count;

  int vectors     = 0;
  int miscompares = 0;

  cmp_sort_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Swaps in a stable bubble sort equal the number of strict inversions
  function automatic int model_swaps(input int v[N]);
    int s = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (v[a] > v[b]) s++;
    return s;
  endfunction

  // Each pass moves every element with a larger left neighbour one step left, so
  // the passes that swap equal the largest "greater-to-the-left" count; one more
  // clean pass confirms sortedness unless the pass limit is reached first.
  function automatic int model_compares(input int v[N]);
    int p = 0;
    int passes;
    int k = 0;
    for (int a = 0; a < N; a++) begin
      int c = 0;
      for (int b = 0; b < a; b++)
        if (v[b] > v[a]) c++;
      if (c > p) p = c;
    end
    passes = (p + 1 < N - 1) ? p + 1 : N - 1;
    for (int q = 0; q < passes; q++) k += N - 1 - q;
    return k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_burst(input int v[N]);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(v[i]);
      check("load_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // bp_at/bp_len: stall out_ready for bp_len cycles once element bp_at is presented
  task automatic run_burst(input string name, input int v[N], input bit rand_bp,
                           input int bp_at, input int bp_len);
    int exp_q[$];
    int exp_sw;
    int exp_k;
    int cyc;
    int idx;
    int guard;
    int stalled;
    bit hs;
    foreach (v[i]) exp_q.push_back(v[i]);
    exp_q.sort();
    exp_sw = model_swaps(v);
    exp_k  = model_compares(v);

    load_burst(v);
    check({name, "_busy_first_sort"}, 32'(busy), 32'd1);
    check({name, "_in_ready_sort"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      in_valid = 1'($urandom);
      in_data  = 4'($urandom);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check({name, "_sort_cycles"}, 32'(cyc), 32'(exp_k));
    check({name, "_swap_count"}, 32'(swap_count), 32'(exp_sw));

    idx = 0;
    guard = 0;
    stalled = 0;
    while (idx < N && guard < 200) begin
      check({name, "_out_valid"}, 32'(out_valid), 32'd1);
      check({name, "_out_data"}, 32'(out_data), 32'(exp_q[idx]));
      if (rand_bp) out_ready = 1'($urandom);
      else if (idx == bp_at && stalled < bp_len) begin
        out_ready = 1'b0;
        stalled++;
      end else out_ready = 1'b1;
      hs = out_ready && out_valid;
      step();
      if (hs) idx++;
      guard++;
    end
    out_ready = 1'b0;
    check({name, "_drained_all"}, 32'(idx), 32'(N));
    check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({name, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_swap_held"}, 32'(swap_count), 32'(exp_sw));
  endtask

  initial begin
    int b[N];
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    do_reset();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_swap_count", 32'(swap_count), 32'd0);

    b = '{1, 2, 3, 4};   run_burst("sorted", b, 1'b0, 0, 0);
    b = '{15, 9, 4, 0};  run_burst("reverse", b, 1'b0, 0, 0);
    b = '{3, 0, 15, 3};  run_burst("early_exit", b, 1'b0, 0, 0);
    b = '{5, 5, 5, 5};   run_burst("all_equal", b, 1'b0, 0, 0);
    b = '{15, 9, 4, 0};  run_burst("backpressure", b, 1'b0, 1, 3);

    // Reset in the second compare cycle must discard the burst
    b = '{15, 9, 4, 0};
    load_burst(b);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midsort_rst_in_ready", 32'(in_ready), 32'd1);
    check("midsort_rst_busy", 32'(busy), 32'd0);
    check("midsort_rst_out_valid", 32'(out_valid), 32'd0);
    check("midsort_rst_swap_count", 32'(swap_count), 32'd0);
    b = '{2, 1, 4, 3};   run_burst("after_rst", b, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) b[i] = int'($urandom_range(0, (t % 2 == 1) ? 3 : 15));
      run_burst("random", b, 1'b1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
